spi_command_decoder: RTL and testbench
======================================

// Module: spi_command_decoder
// PURPOSE
// - Sits between the SPI slave shift register and the driver/backend array. Captures each 32-bit word
//   on a latch_data rising edge, decodes the opcode and issues one-hot driver writes, config-register
//   writes or control actions. Also generates the backend start pulse from control_trigger.
// PARAMETERS
// - NUM_OF_DRIVERS  10  driver count; width of drv_sel, valid driver indices 0..NUM_OF_DRIVERS-1
// - SYNC_STAGES     2   synchronizer depth for latch_data and control_trigger (>=2)
// PORTS
// - clock            in   1   system clock
// - reset            in   1   synchronous, active-high reset
// - spi_word         in   32  parallel word from SPI shift register; stable while latch_data high
// - latch_data       in   1   async pad input; rising edge = word complete
// - control_trigger  in   1   async pad input; rising edge = start request
// - drv_wr_valid     out  1   driver write request
// - drv_wr_ready     in   1   addressed driver accepts (transfer when valid&ready)
// - drv_sel          out  NUM_OF_DRIVERS  one-hot driver select, zero when drv_wr_valid low
// - drv_wr_cmd       out  32  decoded word forwarded to selected driver (MEM/DOT/SEL formats)
// - cfg_ccr0, cfg_ccr1, cfg_ordering_complete  out  32 each  backend timing registers
// - cfg_row_limit, cfg_col_limit, cfg_inverter_select, cfg_row_col_select  out  16 each
// - ctrl_mode        out  4   control bits [29:26] of last CONTROL word (bit3 = oneshot arm)
// - start_pulse      out  1   one-cycle backend start
// - backend_busy     in   1   backend running an update cycle
// - cmd_error        out  1   sticky error flag, cleared only by reset
// BEHAVIOUR
// - Reset: all outputs 0; all cfg registers 0; FSM -> IDLE; pending flag cleared; sync chains cleared.
// - latch_data/control_trigger each pass SYNC_STAGES flops then edge detect (1-cycle rise pulse).
// - On latch rise: spi_word captured into cmd_q. If FSM not IDLE, word goes to 1-deep pending buffer;
//   a further rise while pending is full is dropped and sets cmd_error.
// - FSM: IDLE -> DECODE (1 cycle) -> ISSUE (driver cmds only, hold until valid&ready) -> IDLE.
//   Config/control words complete in DECODE. On return to IDLE with pending set, pending loads next cycle.
// - Decode on cmd[31:30]:
//   00 MEM / 01 DOT: driver = cmd[29:26]; drive drv_sel one-hot, drv_wr_cmd = cmd, valid in ISSUE.
//   10 with cmd[22]=1 SEL: same as MEM/DOT. 10 with cmd[22]=0 CONFIG: addr cmd[21:16], data cmd[15:0];
//     addr 0/1 = ccr0 lo/hi, 2/3 = ccr1 lo/hi, 4/5 = ordering_complete lo/hi, 6 row_limit, 7 col_limit,
//     8 inverter_select, 9 row_col_select; write lands cycle after DECODE.
//   11 CONTROL: ctrl_mode <= cmd[29:26].
// - Driver index >= NUM_OF_DRIVERS or CONFIG addr > 9: no write, cmd_error set, FSM returns IDLE.
// - Latency: latch pad rise -> drv_wr_valid = SYNC_STAGES+3 cycles (ready assumed high).
// - drv_wr_valid/drv_sel/drv_wr_cmd held stable until accepted; no timeout.
// - start_pulse: trigger rise while ctrl_mode[3]=1 and backend_busy=0 -> one-cycle pulse next cycle.
//   Trigger rise while busy or not armed: ignored (no error). Trigger held high gives one pulse only.
// - Simultaneous latch rise and trigger rise: both serviced independently (separate paths).
// - Reset asserted mid-ISSUE: valid drops next edge; pending word discarded.
// CONFIGURATION
// - DECODER_ERR_CNT_EN defined: extra output err_count[7:0], increments on every error event
//   (dropped word, bad driver, bad cfg addr), saturates at 255, reset to 0. cmd_error unchanged.
// - Not defined: port and counter absent; only sticky cmd_error.
// TESTING
// - Config 0x80000020 then 0x80010000 -> cfg_ccr0 = 0x00000020; addr 6 data 4 -> cfg_row_limit = 4.
// - MEM word 0x0C80FFFF (driver 3, mask 1, addr 0) -> drv_sel = 10'b0000001000, drv_wr_cmd = word;
//   hold ready low 5 cycles -> valid/outputs stable until ready.
// - Driver 12 word 0x30000001 -> no valid, cmd_error = 1; config addr 10 -> no cfg change, error.
// - 0xE0000000 (CONTROL, mode 4'b1000) then trigger rise, busy=0 -> exactly one start_pulse;
//   repeat with busy=1 -> no pulse; trigger with mode 0 -> no pulse.
// - Three latch rises while ready held low -> first issued, second pending then issued, third
//   dropped with cmd_error (err_count = 1 when DECODER_ERR_CNT_EN).
// - Reset during ISSUE -> valid low next cycle, all cfg 0, pending word never issued.

Source files
------------

// File: rtl/spi_command_decoder_if.sv
// ---------------------------------------------------------------------------
// spi_command_decoder_if
// Driver write bus between the SPI command decoder and the driver array.
//   drv_wr_valid : write request from the decoder
//   drv_wr_ready : addressed driver accepts (transfer when valid & ready)
//   drv_sel      : one-hot driver select, zero whenever drv_wr_valid is low
//   drv_wr_cmd   : 32-bit command word forwarded to the selected driver
// Modports: master = decoder side, slave = driver array side.
// ---------------------------------------------------------------------------
interface spi_command_decoder_if #(
  parameter int NUM_OF_DRIVERS = 10
);
  logic                      drv_wr_valid;
  logic                      drv_wr_ready;
  logic [NUM_OF_DRIVERS-1:0] drv_sel;
  logic [31:0]               drv_wr_cmd;

  modport master (
    output drv_wr_valid,
    output drv_sel,
    output drv_wr_cmd,
    input  drv_wr_ready
  );

  modport slave (
    input  drv_wr_valid,
    input  drv_sel,
    input  drv_wr_cmd,
    output drv_wr_ready
  );
endinterface

// File: rtl/spi_command_decoder.sv
// ---------------------------------------------------------------------------
// spi_command_decoder
// Captures each 32-bit word from the SPI slave shift register on a rising
// edge of latch_data, decodes the opcode in bits [31:30] and either issues a
// one-hot driver write, writes a backend config register half, or updates the
// control mode. Also turns control_trigger rises into a one-cycle backend
// start pulse when armed (ctrl_mode[3]) and the backend is idle.
//
// Ports
//   i_clock, i_reset        : system clock, synchronous active-high reset
//   i_spi_word              : parallel word, stable while latch_data is high
//   i_latch_data            : async pad, rising edge = word complete
//   i_control_trigger       : async pad, rising edge = start request
//   drv_if (master)         : driver write bus (valid/ready/sel/cmd)
//   o_cfg_*                 : backend timing/config registers
//   o_ctrl_mode             : bits [29:26] of the last CONTROL word
//   o_start_pulse           : one-cycle backend start
//   i_backend_busy          : backend running an update cycle
//   o_cmd_error             : sticky error flag, cleared only by reset
//   o_err_count             : saturating error-event counter (optional)
//
// Build option: define DECODER_ERR_CNT_EN to add o_err_count[7:0].
// ---------------------------------------------------------------------------
module spi_command_decoder #(
  parameter int NUM_OF_DRIVERS = 10,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [31:0]           i_spi_word,
  input  logic                  i_latch_data,
  input  logic                  i_control_trigger,
  spi_command_decoder_if.master drv_if,
  output logic [31:0]           o_cfg_ccr0,
  output logic [31:0]           o_cfg_ccr1,
  output logic [31:0]           o_cfg_ordering_complete,
  output logic [15:0]           o_cfg_row_limit,
  output logic [15:0]           o_cfg_col_limit,
  output logic [15:0]           o_cfg_inverter_select,
  output logic [15:0]           o_cfg_row_col_select,
  output logic [3:0]            o_ctrl_mode,
  output logic                  o_start_pulse,
  input  logic                  i_backend_busy,
  output logic                  o_cmd_error
`ifdef DECODER_ERR_CNT_EN
  ,
  output logic [7:0]            o_err_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2
  } state_t;

  // One-hot select for a driver index; indices outside the array give zero.
  function automatic logic [NUM_OF_DRIVERS-1:0] f_onehot(input logic [3:0] idx);
    logic [NUM_OF_DRIVERS-1:0] v;
    v = {NUM_OF_DRIVERS{1'b0}};
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      v[i] = (32'(idx) == $unsigned(i));
    end
    return v;
  endfunction

  // Synchronizers and edge detect state
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_trig_sync;
  logic                   r_latch_prev;
  logic                   r_trig_prev;
  logic                   w_latch_rise;
  logic                   w_trig_rise;

  // Command path
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_cmd_q;
  logic [31:0]            r_pend_word;
  logic                   r_pend_full;
  logic                   w_direct_load;
  logic                   w_pend_load;
  logic                   w_pend_accept;
  logic                   w_drop;

  // Decode fields
  logic [1:0]             w_opcode;
  logic [3:0]             w_drv_idx;
  logic [5:0]             w_cfg_addr;
  logic [15:0]            w_cfg_data;
  logic                   w_is_drv;
  logic                   w_is_cfg;
  logic                   w_is_ctrl;
  logic                   w_drv_idx_ok;
  logic                   w_cfg_addr_ok;
  logic                   w_in_decode;
  logic                   w_bad_drv;
  logic                   w_bad_cfg;
  logic                   w_cfg_wr;
  logic                   w_ctrl_wr;
  logic                   w_err_any;

  // Registered driver bus and their next values
  logic                      r_drv_valid;
  logic [NUM_OF_DRIVERS-1:0] r_drv_sel;
  logic [31:0]               r_drv_cmd;
  logic                      w_valid_nxt;
  logic [NUM_OF_DRIVERS-1:0] w_sel_nxt;
  logic [31:0]               w_cmd_nxt;

  // Config / control / status registers
  logic [31:0]            r_cfg_ccr0;
  logic [31:0]            r_cfg_ccr1;
  logic [31:0]            r_cfg_ordering_complete;
  logic [15:0]            r_cfg_row_limit;
  logic [15:0]            r_cfg_col_limit;
  logic [15:0]            r_cfg_inverter_select;
  logic [15:0]            r_cfg_row_col_select;
  logic [3:0]             r_ctrl_mode;
  logic                   r_start_pulse;
  logic                   r_cmd_error;

  // Pad synchronizers plus the previous synchronized value for edge detect
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_latch_sync <= {SYNC_STAGES{1'b0}};
      r_trig_sync  <= {SYNC_STAGES{1'b0}};
      r_latch_prev <= 1'b0;
      r_trig_prev  <= 1'b0;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], i_latch_data};
      r_trig_sync  <= {r_trig_sync[SYNC_STAGES-2:0], i_control_trigger};
      r_latch_prev <= r_latch_sync[SYNC_STAGES-1];
      r_trig_prev  <= r_trig_sync[SYNC_STAGES-1];
    end
  end

  assign w_latch_rise = r_latch_sync[SYNC_STAGES-1] & ~r_latch_prev;
  assign w_trig_rise  = r_trig_sync[SYNC_STAGES-1] & ~r_trig_prev;

  // In IDLE a held pending word is consumed first; a rise in that same cycle
  // refills the buffer, so only a rise against a full, non-draining buffer drops.
  assign w_direct_load = w_latch_rise & (r_state == ST_IDLE) & ~r_pend_full;
  assign w_pend_load   = (r_state == ST_IDLE) & r_pend_full;
  assign w_pend_accept = w_latch_rise & ~w_direct_load & (~r_pend_full | w_pend_load);
  assign w_drop        = w_latch_rise & r_pend_full & ~w_pend_load;

  assign w_opcode      = r_cmd_q[31:30];
  assign w_drv_idx     = r_cmd_q[29:26];
  assign w_cfg_addr    = r_cmd_q[21:16];
  assign w_cfg_data    = r_cmd_q[15:0];
  // SEL words share opcode 10 with CONFIG and are told apart by bit 22.
  assign w_is_drv      = (w_opcode == 2'b00) | (w_opcode == 2'b01) |
                         ((w_opcode == 2'b10) & r_cmd_q[22]);
  assign w_is_cfg      = (w_opcode == 2'b10) & ~r_cmd_q[22];
  assign w_is_ctrl     = (w_opcode == 2'b11);
  assign w_drv_idx_ok  = (32'(w_drv_idx) < $unsigned(NUM_OF_DRIVERS));
  assign w_cfg_addr_ok = (w_cfg_addr <= 6'd9);
  assign w_in_decode   = (r_state == ST_DECODE);
  assign w_bad_drv     = w_in_decode & w_is_drv & ~w_drv_idx_ok;
  assign w_bad_cfg     = w_in_decode & w_is_cfg & ~w_cfg_addr_ok;
  assign w_cfg_wr      = w_in_decode & w_is_cfg & w_cfg_addr_ok;
  assign w_ctrl_wr     = w_in_decode & w_is_ctrl;
  assign w_err_any     = w_drop | w_bad_drv | w_bad_cfg;

  // Word capture into cmd_q and the one-deep pending buffer
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cmd_q     <= 32'd0;
      r_pend_word <= 32'd0;
      r_pend_full <= 1'b0;
    end else begin
      if (w_direct_load) begin
        r_cmd_q <= i_spi_word;
      end else if (w_pend_load) begin
        r_cmd_q <= r_pend_word;
      end else begin
        r_cmd_q <= r_cmd_q;
      end
      if (w_pend_accept) begin
        r_pend_word <= i_spi_word;
        r_pend_full <= 1'b1;
      end else if (w_pend_load) begin
        r_pend_full <= 1'b0;
      end else begin
        r_pend_full <= r_pend_full;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_direct_load || w_pend_load) begin
          w_state_nxt = ST_DECODE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: begin
        // Config, control and rejected words all finish here.
        if (w_is_drv && w_drv_idx_ok) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (r_drv_valid && drv_if.drv_wr_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: next values for the registered driver bus
  always_comb begin
    w_valid_nxt = 1'b0;
    w_sel_nxt   = {NUM_OF_DRIVERS{1'b0}};
    w_cmd_nxt   = 32'd0;
    // Valid trails the ISSUE state by one register; it drops on the edge that
    // completes the transfer.
    if ((r_state == ST_ISSUE) && !(r_drv_valid && drv_if.drv_wr_ready)) begin
      w_valid_nxt = 1'b1;
      w_sel_nxt   = f_onehot(w_drv_idx);
      w_cmd_nxt   = r_cmd_q;
    end else begin
      w_valid_nxt = 1'b0;
      w_sel_nxt   = {NUM_OF_DRIVERS{1'b0}};
      w_cmd_nxt   = 32'd0;
    end
  end

  // Driver bus output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_drv_valid <= 1'b0;
      r_drv_sel   <= {NUM_OF_DRIVERS{1'b0}};
      r_drv_cmd   <= 32'd0;
    end else begin
      r_drv_valid <= w_valid_nxt;
      r_drv_sel   <= w_sel_nxt;
      r_drv_cmd   <= w_cmd_nxt;
    end
  end

  // Config register writes, landing on the edge that ends DECODE
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cfg_ccr0              <= 32'd0;
      r_cfg_ccr1              <= 32'd0;
      r_cfg_ordering_complete <= 32'd0;
      r_cfg_row_limit         <= 16'd0;
      r_cfg_col_limit         <= 16'd0;
      r_cfg_inverter_select   <= 16'd0;
      r_cfg_row_col_select    <= 16'd0;
    end else if (w_cfg_wr) begin
      case (w_cfg_addr)
        6'd0:    r_cfg_ccr0[15:0]               <= w_cfg_data;
        6'd1:    r_cfg_ccr0[31:16]              <= w_cfg_data;
        6'd2:    r_cfg_ccr1[15:0]               <= w_cfg_data;
        6'd3:    r_cfg_ccr1[31:16]              <= w_cfg_data;
        6'd4:    r_cfg_ordering_complete[15:0]  <= w_cfg_data;
        6'd5:    r_cfg_ordering_complete[31:16] <= w_cfg_data;
        6'd6:    r_cfg_row_limit                <= w_cfg_data;
        6'd7:    r_cfg_col_limit                <= w_cfg_data;
        6'd8:    r_cfg_inverter_select          <= w_cfg_data;
        6'd9:    r_cfg_row_col_select           <= w_cfg_data;
        default: r_cfg_row_col_select           <= r_cfg_row_col_select;
      endcase
    end else begin
      r_cfg_ccr0 <= r_cfg_ccr0;
    end
  end

  // Control mode register, written by CONTROL words
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ctrl_mode <= 4'd0;
    end else if (w_ctrl_wr) begin
      r_ctrl_mode <= r_cmd_q[29:26];
    end else begin
      r_ctrl_mode <= r_ctrl_mode;
    end
  end

  // Backend start: one pulse per trigger rise when armed and backend idle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_start_pulse <= 1'b0;
    end else begin
      r_start_pulse <= w_trig_rise & r_ctrl_mode[3] & ~i_backend_busy;
    end
  end

  // Sticky error flag
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cmd_error <= 1'b0;
    end else begin
      r_cmd_error <= r_cmd_error | w_err_any;
    end
  end

`ifdef DECODER_ERR_CNT_EN
  // A drop and a decode error can coincide, so up to two events per cycle.
  logic [7:0] r_err_count;
  logic [1:0] w_err_evt_cnt;
  logic [8:0] w_err_sum;

  assign w_err_evt_cnt = {1'b0, w_drop} + {1'b0, (w_bad_drv | w_bad_cfg)};
  assign w_err_sum     = {1'b0, r_err_count} + {7'd0, w_err_evt_cnt};

  // Saturating error-event counter
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_err_count <= 8'd0;
    end else if (w_err_sum > 9'd255) begin
      r_err_count <= 8'd255;
    end else begin
      r_err_count <= w_err_sum[7:0];
    end
  end

  assign o_err_count = r_err_count;
`else
  // Without the counter only the sticky flag records errors.
`endif

  assign drv_if.drv_wr_valid     = r_drv_valid;
  assign drv_if.drv_sel          = r_drv_sel;
  assign drv_if.drv_wr_cmd       = r_drv_cmd;
  assign o_cfg_ccr0              = r_cfg_ccr0;
  assign o_cfg_ccr1              = r_cfg_ccr1;
  assign o_cfg_ordering_complete = r_cfg_ordering_complete;
  assign o_cfg_row_limit         = r_cfg_row_limit;
  assign o_cfg_col_limit         = r_cfg_col_limit;
  assign o_cfg_inverter_select   = r_cfg_inverter_select;
  assign o_cfg_row_col_select    = r_cfg_row_col_select;
  assign o_ctrl_mode             = r_ctrl_mode;
  assign o_start_pulse           = r_start_pulse;
  assign o_cmd_error             = r_cmd_error;

endmodule

// File: tb/tb_spi_command_decoder.sv
// ---------------------------------------------------------------------------
// tb_spi_command_decoder
// Directed and randomized stimulus for spi_command_decoder. Expected values
// come from a word-level model: an array of ten 16-bit config halves, the
// control mode, the sticky error flag and the error count.
// ---------------------------------------------------------------------------
module tb_spi_command_decoder;
  localparam int N = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] spi_word;
  logic        latch;
  logic        trig;
  logic        busy;
  logic [31:0] cfg_ccr0, cfg_ccr1, cfg_ord;
  logic [15:0] cfg_row, cfg_col, cfg_inv, cfg_rcs;
  logic [3:0]  ctrl_mode;
  logic        start_pulse;
  logic        cmd_error;
`ifdef DECODER_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  spi_command_decoder_if #(.NUM_OF_DRIVERS(N)) drv_bus ();

  spi_command_decoder #(.NUM_OF_DRIVERS(N), .SYNC_STAGES(2)) dut (
    .i_clock                 (clk),
    .i_reset                 (reset),
    .i_spi_word              (spi_word),
    .i_latch_data            (latch),
    .i_control_trigger       (trig),
    .drv_if                  (drv_bus),
    .o_cfg_ccr0              (cfg_ccr0),
    .o_cfg_ccr1              (cfg_ccr1),
    .o_cfg_ordering_complete (cfg_ord),
    .o_cfg_row_limit         (cfg_row),
    .o_cfg_col_limit         (cfg_col),
    .o_cfg_inverter_select   (cfg_inv),
    .o_cfg_row_col_select    (cfg_rcs),
    .o_ctrl_mode             (ctrl_mode),
    .o_start_pulse           (start_pulse),
    .i_backend_busy          (busy),
    .o_cmd_error             (cmd_error)
`ifdef DECODER_ERR_CNT_EN
    ,
    .o_err_count             (err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_half [0:9];
  logic [3:0]  m_mode;
  bit          m_err;
  int          m_err_cnt;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 10; i++) m_half[i] = 16'd0;
    m_mode    = 4'd0;
    m_err     = 1'b0;
    m_err_cnt = 0;
  endfunction

  function automatic void err_event();
    m_err = 1'b1;
    if (m_err_cnt < 255) m_err_cnt++;
  endfunction

  // Returns 1 when the word must produce a driver transfer.
  function automatic bit model_apply(input logic [31:0] w);
    int idx;
    int addr;
    idx  = int'(w[29:26]);
    addr = int'(w[21:16]);
    if (w[31:30] == 2'b11) begin
      m_mode = w[29:26];
      return 1'b0;
    end else if (w[31:30] == 2'b10 && w[22] == 1'b0) begin
      if (addr <= 9) m_half[addr] = w[15:0];
      else err_event();
      return 1'b0;
    end else begin
      if (idx < N) return 1'b1;
      err_event();
      return 1'b0;
    end
  endfunction

  task automatic check_state(input string tag);
    chk({tag, " ccr0"}, cfg_ccr0, {m_half[1], m_half[0]});
    chk({tag, " ccr1"}, cfg_ccr1, {m_half[3], m_half[2]});
    chk({tag, " ord"},  cfg_ord,  {m_half[5], m_half[4]});
    chk({tag, " row"},  32'(cfg_row), 32'(m_half[6]));
    chk({tag, " col"},  32'(cfg_col), 32'(m_half[7]));
    chk({tag, " inv"},  32'(cfg_inv), 32'(m_half[8]));
    chk({tag, " rcs"},  32'(cfg_rcs), 32'(m_half[9]));
    chk({tag, " mode"}, 32'(ctrl_mode), 32'(m_mode));
    chk({tag, " err"},  32'(cmd_error), 32'(m_err));
`ifdef DECODER_ERR_CNT_EN
    chk({tag, " errcnt"}, 32'(err_count), 32'(m_err_cnt));
`endif
  endtask

  task automatic wait_valid(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick(1);
      if (drv_bus.drv_wr_valid) seen = 1'b1;
    end
  endtask

  task automatic pulse_latch(input logic [31:0] w, input int hi, input int lo);
    spi_word = w;
    latch = 1'b1;
    tick(hi);
    latch = 1'b0;
    tick(lo);
  endtask

  // One word from IDLE: ready held low for 'hold' cycles once valid shows.
  task automatic do_word(input logic [31:0] w, input int hold, input string tag);
    bit exp_x;
    bit seen;
    logic [N-1:0] one_v;
    logic [N-1:0] exp_sel;
    one_v   = 1;
    exp_sel = one_v << w[29:26];
    exp_x   = model_apply(w);
    drv_bus.drv_wr_ready = 1'b0;
    spi_word = w;
    latch = 1'b1;
    tick(3);
    latch = 1'b0;
    wait_valid(10, seen);
    if (exp_x) begin
      chk({tag, " seen"}, 32'(seen), 32'd1);
      if (seen) begin
        chk({tag, " sel"}, 32'(drv_bus.drv_sel), 32'(exp_sel));
        chk({tag, " cmd"}, drv_bus.drv_wr_cmd, w);
        for (int h = 0; h < hold; h++) begin
          tick(1);
          chk({tag, " hold valid"}, 32'(drv_bus.drv_wr_valid), 32'd1);
        end
        chk({tag, " hold sel"}, 32'(drv_bus.drv_sel), 32'(exp_sel));
        chk({tag, " hold cmd"}, drv_bus.drv_wr_cmd, w);
        drv_bus.drv_wr_ready = 1'b1;
        tick(1);
        chk({tag, " accepted"}, 32'(drv_bus.drv_wr_valid), 32'd0);
        drv_bus.drv_wr_ready = 1'b0;
      end
    end else begin
      chk({tag, " novalid"}, 32'(seen), 32'd0);
    end
    tick(2);
    check_state(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    latch = 1'b0;
    trig  = 1'b0;
    drv_bus.drv_wr_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    model_clear();
    tick(1);
  endtask

  initial begin
    bit          seen;
    int          pulses;
    int          first;
    logic [31:0] w;

    reset = 1'b1; spi_word = 32'd0; latch = 1'b0; trig = 1'b0; busy = 1'b0;
    drv_bus.drv_wr_ready = 1'b0;
    do_reset();
    check_state("reset");
    chk("reset valid", 32'(drv_bus.drv_wr_valid), 32'd0);
    chk("reset sel", 32'(drv_bus.drv_sel), 32'd0);
    chk("reset cmd", drv_bus.drv_wr_cmd, 32'd0);
    chk("reset start", 32'(start_pulse), 32'd0);

    // Pad rise to valid takes SYNC_STAGES+3 = 5 cycles with ready high.
    drv_bus.drv_wr_ready = 1'b1;
    spi_word = 32'h0C80FFFF;
    latch = 1'b1;
    tick(4);
    chk("lat pre", 32'(drv_bus.drv_wr_valid), 32'd0);
    tick(1);
    chk("lat valid", 32'(drv_bus.drv_wr_valid), 32'd1);
    chk("lat sel", 32'(drv_bus.drv_sel), 32'h008);
    chk("lat cmd", drv_bus.drv_wr_cmd, 32'h0C80FFFF);
    latch = 1'b0;
    tick(1);
    chk("lat done", 32'(drv_bus.drv_wr_valid), 32'd0);
    drv_bus.drv_wr_ready = 1'b0;
    tick(3);

    do_word(32'h0C80FFFF, 5, "mem_hold");
    do_word(32'h80000020, 0, "cfg_a0");
    do_word(32'h80010000, 0, "cfg_a1");
    do_word(32'h80060004, 0, "cfg_a6");
    chk("ccr0 value", cfg_ccr0, 32'h00000020);
    chk("row value", 32'(cfg_row), 32'd4);
    chk("no err yet", 32'(cmd_error), 32'd0);
    do_word(32'h30000001, 0, "drv12");
    chk("drv12 err", 32'(cmd_error), 32'd1);
    do_word(32'h800A0001, 0, "cfg_a10");

    // Start pulse: armed and idle gives exactly one pulse, two cycles after sync.
    do_word(32'hE0000000, 0, "ctrl_arm");
    chk("mode armed", 32'(ctrl_mode), 32'h8);
    busy = 1'b0; trig = 1'b1; pulses = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (start_pulse) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("trig one pulse", 32'(pulses), 32'd1);
    chk("trig pulse cycle", 32'(first), 32'd2);
    trig = 1'b0; tick(4);
    busy = 1'b1; trig = 1'b1; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (start_pulse) pulses++;
    end
    chk("trig busy", 32'(pulses), 32'd0);
    trig = 1'b0; busy = 1'b0; tick(4);
    do_word(32'hC0000000, 0, "ctrl_disarm");
    trig = 1'b1; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (start_pulse) pulses++;
    end
    chk("trig unarmed", 32'(pulses), 32'd0);
    trig = 1'b0; tick(4);

    // Three words with ready low: first issued, second pending, third dropped.
    do_reset();
    pulse_latch(32'h04000011, 2, 3);
    pulse_latch(32'h08000022, 2, 3);
    chk("three no err", 32'(cmd_error), 32'd0);
    pulse_latch(32'h14000033, 2, 3);
    tick(2);
    err_event();
    check_state("three drop");
    chk("three A valid", 32'(drv_bus.drv_wr_valid), 32'd1);
    chk("three A sel", 32'(drv_bus.drv_sel), 32'h002);
    chk("three A cmd", drv_bus.drv_wr_cmd, 32'h04000011);
    drv_bus.drv_wr_ready = 1'b1;
    tick(1);
    chk("three A gone", 32'(drv_bus.drv_wr_valid), 32'd0);
    wait_valid(12, seen);
    chk("three B seen", 32'(seen), 32'd1);
    chk("three B sel", 32'(drv_bus.drv_sel), 32'h004);
    chk("three B cmd", drv_bus.drv_wr_cmd, 32'h08000022);
    wait_valid(15, seen);
    chk("three C dropped", 32'(seen), 32'd0);
    drv_bus.drv_wr_ready = 1'b0;

    // Randomized words against the model.
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[31:30] = 2'b00;
        1: w[31:30] = 2'b01;
        2: begin
          w[31:30] = 2'b10;
          if ($urandom_range(0, 1) == 0) begin
            w[22]    = 1'b0;
            w[21:16] = 6'($urandom_range(0, 11));
          end else begin
            w[22] = 1'b1;
          end
        end
        default: w[31:30] = 2'b11;
      endcase
      do_word(w, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // Reset while a transfer is held: valid drops, cfg clears, pending lost.
    do_reset();
    do_word(32'h80070005, 0, "pre_rst_cfg");
    chk("pre rst col", 32'(cfg_col), 32'd5);
    pulse_latch(32'h10000044, 2, 3);
    pulse_latch(32'h0C000055, 2, 3);
    chk("mid valid", 32'(drv_bus.drv_wr_valid), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("rst valid low", 32'(drv_bus.drv_wr_valid), 32'd0);
    chk("rst sel zero", 32'(drv_bus.drv_sel), 32'd0);
    chk("rst col zero", 32'(cfg_col), 32'd0);
    reset = 1'b0;
    model_clear();
    drv_bus.drv_wr_ready = 1'b1;
    wait_valid(15, seen);
    chk("pending discarded", 32'(seen), 32'd0);
    check_state("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
